// File: rtl/vga_sync_gen_pkg.sv
// Shared 640x480@60 raster timing constants and parameter sanity helper,
// used by the sync generator, pattern and sync-to-count blocks.
package vga_timing;

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned CNT_MAX = 1 << CNT_W;

  localparam int unsigned H_TOTAL       = 800;
  localparam int unsigned H_ACTIVE      = 640;
  localparam int unsigned H_FRONT_PORCH = 16;
  localparam int unsigned H_SYNC_WIDTH  = 96;

  localparam int unsigned V_TOTAL       = 525;
  localparam int unsigned V_ACTIVE      = 480;
  localparam int unsigned V_FRONT_PORCH = 10;
  localparam int unsigned V_SYNC_WIDTH  = 2;

  // Sync window must fit inside the line/frame, and the counter is CNT_W bits wide.
  function automatic bit axis_params_ok(input int unsigned total,
                                        input int unsigned active,
                                        input int unsigned front_porch,
                                        input int unsigned sync_width);
    return (total != 0) && (active + front_porch + sync_width <= total) && (total <= CNT_MAX);
  endfunction

endpackage

// File: rtl/vga_sync_gen_axis.sv
// One raster axis: wrapping position counter with registered sync and active
// flags that always describe the count presented in the same cycle.
module vga_axis_timing import vga_timing::*; #(
  parameter int unsigned TOTAL       = H_TOTAL,
  parameter int unsigned ACTIVE      = H_ACTIVE,
  parameter int unsigned FRONT_PORCH = H_FRONT_PORCH,
  parameter int unsigned SYNC_WIDTH  = H_SYNC_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_advance,
  output logic [CNT_W-1:0] o_count,
  output logic             o_sync_n,
  output logic             o_next_active,
  output logic             o_wrap
);

  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SYNC_FIRST = CNT_W'(ACTIVE + FRONT_PORCH);
  localparam logic [CNT_W-1:0] SYNC_LAST  = CNT_W'(ACTIVE + FRONT_PORCH + SYNC_WIDTH - 1);
  localparam logic [CNT_W:0]   ACTIVE_END = (CNT_W + 1)'(ACTIVE);

  if (!axis_params_ok(TOTAL, ACTIVE, FRONT_PORCH, SYNC_WIDTH)) begin : g_bad_params
    $error("vga_axis_timing: need ACTIVE+FRONT_PORCH+SYNC_WIDTH <= TOTAL <= 1024");
  end

  logic [CNT_W-1:0] r_count;
  logic             r_sync_n;
  logic             r_active;
  logic [CNT_W-1:0] w_next;
  logic             w_next_sync_n;
  logic             w_next_active;
  logic             w_at_last;

  // Flags are decoded from the value being loaded so they land with the count.
  always_comb begin
    w_at_last     = (r_count == LAST);
    w_next        = w_at_last ? '0 : r_count + CNT_W'(1);
    w_next_sync_n = !((w_next >= SYNC_FIRST) && (w_next <= SYNC_LAST));
    w_next_active = ({1'b0, w_next} < ACTIVE_END);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count  <= LAST;
      r_sync_n <= 1'b1;
      r_active <= 1'b0;
    end else if (i_advance) begin
      r_count  <= w_next;
      r_sync_n <= w_next_sync_n;
      r_active <= w_next_active;
    end
  end

  assign o_count       = r_count;
  assign o_sync_n      = r_sync_n;
  assign o_next_active = i_advance ? w_next_active : r_active;
  assign o_wrap        = i_advance && w_at_last;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster/sync generator: horizontal and vertical axis timers chained by
// the line wrap, with registered active and frame-start outputs.
module vga_sync_gen import vga_timing::*; #(
  parameter int unsigned TOTAL_COLS    = H_TOTAL,
  parameter int unsigned TOTAL_ROWS    = V_TOTAL,
  parameter int unsigned ACTIVE_COLS   = H_ACTIVE,
  parameter int unsigned ACTIVE_ROWS   = V_ACTIVE,
  parameter int unsigned H_FRONT_PORCH = vga_timing::H_FRONT_PORCH,
  parameter int unsigned H_SYNC_WIDTH  = vga_timing::H_SYNC_WIDTH,
  parameter int unsigned V_FRONT_PORCH = vga_timing::V_FRONT_PORCH,
  parameter int unsigned V_SYNC_WIDTH  = vga_timing::V_SYNC_WIDTH
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  output logic       hsync,
  output logic       vsync,
  output logic [9:0] col,
  output logic [9:0] row,
  output logic       active,
  output logic       framestart
);

  logic w_h_wrap;
  logic w_v_wrap;
  logic w_h_next_active;
  logic w_v_next_active;
  logic r_active;
  logic r_framestart;

  vga_axis_timing #(
    .TOTAL       (TOTAL_COLS),
    .ACTIVE      (ACTIVE_COLS),
    .FRONT_PORCH (H_FRONT_PORCH),
    .SYNC_WIDTH  (H_SYNC_WIDTH)
  ) u_h_axis (
    .i_clk         (clock),
    .i_rst_n       (reset_n),
    .i_advance     (enable),
    .o_count       (col),
    .o_sync_n      (hsync),
    .o_next_active (w_h_next_active),
    .o_wrap        (w_h_wrap)
  );

  vga_axis_timing #(
    .TOTAL       (TOTAL_ROWS),
    .ACTIVE      (ACTIVE_ROWS),
    .FRONT_PORCH (V_FRONT_PORCH),
    .SYNC_WIDTH  (V_SYNC_WIDTH)
  ) u_v_axis (
    .i_clk         (clock),
    .i_rst_n       (reset_n),
    .i_advance     (w_h_wrap),
    .o_count       (row),
    .o_sync_n      (vsync),
    .o_next_active (w_v_next_active),
    .o_wrap        (w_v_wrap)
  );

  // Combined active and frame start are registered here to keep outputs flop-driven.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_active     <= 1'b0;
      r_framestart <= 1'b0;
    end else begin
      r_framestart <= w_h_wrap && w_v_wrap;
      if (enable) begin
        r_active <= w_h_next_active && w_v_next_active;
      end
    end
  end

  assign active     = r_active;
  assign framestart = r_framestart;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench: a default-timing DUT and a tiny-timing DUT share stimulus;
// a linear-pixel-index model predicts every output, a negedge monitor compares.
module tb_vga_sync_gen;

  localparam int NDUT = 2;
  localparam int TC  [NDUT] = '{800, 10};
  localparam int TR  [NDUT] = '{525, 6};
  localparam int AC  [NDUT] = '{640, 4};
  localparam int AR  [NDUT] = '{480, 3};
  localparam int HFP [NDUT] = '{16, 1};
  localparam int HSW [NDUT] = '{96, 2};
  localparam int VFP [NDUT] = '{10, 1};
  localparam int VSW [NDUT] = '{2, 2};

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  always #5 clock = ~clock;

  logic       a_hsync, a_vsync, a_active, a_framestart;
  logic [9:0] a_col, a_row;
  logic       b_hsync, b_vsync, b_active, b_framestart;
  logic [9:0] b_col, b_row;

  vga_sync_gen u_dut_a (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .hsync(a_hsync), .vsync(a_vsync), .col(a_col), .row(a_row),
    .active(a_active), .framestart(a_framestart)
  );

  vga_sync_gen #(
    .TOTAL_COLS(10), .TOTAL_ROWS(6), .ACTIVE_COLS(4), .ACTIVE_ROWS(3),
    .H_FRONT_PORCH(1), .H_SYNC_WIDTH(2), .V_FRONT_PORCH(1), .V_SYNC_WIDTH(2)
  ) u_dut_b (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .hsync(b_hsync), .vsync(b_vsync), .col(b_col), .row(b_row),
    .active(b_active), .framestart(b_framestart)
  );

  typedef struct {
    int col;
    int row;
    bit hs;
    bit vs;
    bit act;
    bit fs;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  // Model state: linear pixel index within the frame, plus reset/frame-start flags.
  int m_pos [NDUT];
  bit m_rst [NDUT];
  bit m_fs  [NDUT];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cycle, act, req);
    end
  endtask

  function automatic exp_t model_out(input int d);
    exp_t e;
    int hs_first, vs_first;
    e.col = m_pos[d] % TC[d];
    e.row = m_pos[d] / TC[d];
    hs_first = AC[d] + HFP[d];
    vs_first = AR[d] + VFP[d];
    e.fs = m_fs[d];
    if (m_rst[d]) begin
      e.hs = 1'b1; e.vs = 1'b1; e.act = 1'b0;
    end else begin
      e.hs  = !(e.col >= hs_first && e.col < hs_first + HSW[d]);
      e.vs  = !(e.row >= vs_first && e.row < vs_first + VSW[d]);
      e.act = (e.col < AC[d]) && (e.row < AR[d]);
    end
    return e;
  endfunction

  task automatic model_edge(input bit rst_n, input bit en);
    for (int d = 0; d < NDUT; d++) begin
      if (!rst_n) begin
        m_pos[d] = TC[d] * TR[d] - 1;
        m_rst[d] = 1'b1;
        m_fs[d]  = 1'b0;
      end else if (en) begin
        m_pos[d] = (m_pos[d] + 1) % (TC[d] * TR[d]);
        m_rst[d] = 1'b0;
        m_fs[d]  = (m_pos[d] == 0);
      end else begin
        m_fs[d] = 1'b0;
      end
    end
  endtask

  task automatic step(input bit rst_n, input bit en);
    reset_n = rst_n;
    enable  = en;
    @(posedge clock);
    #1;
    cycle++;
    model_edge(rst_n, en);
    qa.push_back(model_out(0));
    qb.push_back(model_out(1));
  endtask

  task automatic run_until_col(input int target, input int limit);
    int n = 0;
    while (int'(a_col) != target && n < limit) begin
      step(1'b1, 1'b1);
      n++;
    end
    chk($sformatf("reach_col_%0d", target), int'(a_col), target);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      chk("a_col", int'(a_col), e.col);
      chk("a_row", int'(a_row), e.row);
      chk("a_hsync", int'(a_hsync), int'(e.hs));
      chk("a_vsync", int'(a_vsync), int'(e.vs));
      chk("a_active", int'(a_active), int'(e.act));
      chk("a_framestart", int'(a_framestart), int'(e.fs));
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      chk("b_col", int'(b_col), e.col);
      chk("b_row", int'(b_row), e.row);
      chk("b_hsync", int'(b_hsync), int'(e.hs));
      chk("b_vsync", int'(b_vsync), int'(e.vs));
      chk("b_active", int'(b_active), int'(e.act));
      chk("b_framestart", int'(b_framestart), int'(e.fs));
    end
  end

  initial begin
    int hs_low, hs_first, hs_last, fs_seen, vs_low, last_fs;

    // Reset held five cycles, then released with enable high.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    chk("rst_col", int'(a_col), 799);
    chk("rst_row", int'(a_row), 524);
    chk("rst_active", int'(a_active), 0);
    step(1'b1, 1'b1);
    chk("first_col", int'(a_col), 0);
    chk("first_row", int'(a_row), 0);
    chk("first_active", int'(a_active), 1);
    chk("first_framestart", int'(a_framestart), 1);
    for (int i = 0; i < 639; i++) step(1'b1, 1'b1);
    chk("col639", int'(a_col), 639);
    chk("col639_active", int'(a_active), 1);
    step(1'b1, 1'b1);
    chk("col640", int'(a_col), 640);
    chk("col640_active", int'(a_active), 0);

    // One full line: hsync window and line period.
    run_until_col(799, 2000);
    hs_low = 0; hs_first = -1; hs_last = -1;
    for (int i = 0; i < 800; i++) begin
      step(1'b1, 1'b1);
      if (a_hsync == 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(a_col);
        hs_last = int'(a_col);
      end
    end
    chk("hsync_low_count", hs_low, 96);
    chk("hsync_first_col", hs_first, 656);
    chk("hsync_last_col", hs_last, 751);
    chk("line_period_col", int'(a_col), 799);

    // Hold with enable low just before the sync window.
    run_until_col(655, 2000);
    fs_seen = 0;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0);
      fs_seen += int'(a_framestart) + int'(b_framestart);
      chk("hold_col", int'(a_col), 655);
      chk("hold_hsync", int'(a_hsync), 1);
    end
    chk("hold_framestart_count", fs_seen, 0);
    step(1'b1, 1'b1);
    chk("resume_col", int'(a_col), 656);
    chk("resume_hsync", int'(a_hsync), 0);

    // Randomized enable with occasional reset.
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 599) != 0), ($urandom_range(0, 3) != 0));

    // Tiny-timing DUT: four whole frames straight after reset.
    step(1'b0, 1'b1);
    vs_low = 0; hs_low = 0; fs_seen = 0; last_fs = -1;
    for (int i = 0; i < 240; i++) begin
      step(1'b1, 1'b1);
      if (b_vsync == 1'b0) vs_low++;
      if (b_hsync == 1'b0) hs_low++;
      if (b_framestart == 1'b1) begin
        fs_seen++;
        if (last_fs >= 0) chk("b_frame_period", cycle - last_fs, 60);
        last_fs = cycle;
      end
    end
    chk("b_framestarts", fs_seen, 4);
    chk("b_vsync_low_count", vs_low, 80);
    chk("b_hsync_low_count", hs_low, 48);

    // Reset pulsed mid-line.
    run_until_col(700, 2000);
    step(1'b0, 1'b1);
    chk("midrst_col", int'(a_col), 799);
    chk("midrst_row", int'(a_row), 524);
    chk("midrst_hsync", int'(a_hsync), 1);
    chk("midrst_vsync", int'(a_vsync), 1);
    chk("midrst_active", int'(a_active), 0);
    step(1'b1, 1'b1);
    chk("midrst_framestart", int'(a_framestart), 1);

    @(negedge clock);
    @(negedge clock);
    chk("scoreboard_drain", qa.size() + qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- TOTAL_COLS, 800, pixels per line incl. blanking
- TOTAL_ROWS, 525, lines per frame incl. blanking
- ACTIVE_COLS, 640, visible pixels per line
- ACTIVE_ROWS, 480, visible lines per frame
- H_FRONT_PORCH, 16, pixels between active end and hsync start
- H_SYNC_WIDTH, 96, hsync pulse length, pixels
- V_FRONT_PORCH, 10, lines between active end and vsync start
- V_SYNC_WIDTH, 2, vsync pulse length, lines
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clock, input, 1, pixel clock; one clock; all logic on posedge
- reset_n, input, 1, reset, synchronous, active-low
- enable, input, 1, advance the raster one pixel this cycle when high
- hsync, output, 1, horizontal sync, active-low
- vsync, output, 1, vertical sync, active-low
- col, output, 10, current pixel column, 0..TOTAL_COLS-1
- row, output, 10, current line, 0..TOTAL_ROWS-1
- active, output, 1, high when col<ACTIVE_COLS and row<ACTIVE_ROWS
- framestart, output, 1, one-cycle pulse when (col,row) becomes (0,0)

Function
REQ-003 Every output SHALL be driven directly from a register; no combinational path from any input to any output.
REQ-004 In every cycle, hsync, vsync, active and framestart SHALL describe the col/row values presented in that same cycle (zero relative skew).
REQ-005 On a clock edge with reset_n=1 and enable=1, col SHALL increment by 1; at col=TOTAL_COLS-1 it SHALL wrap to 0 and row SHALL increment.
REQ-006 At col=TOTAL_COLS-1 and row=TOTAL_ROWS-1, both SHALL wrap to 0 on the same edge.
REQ-007 With enable=0, col, row, hsync, vsync and active SHALL hold their values; framestart SHALL be 0.
REQ-008 hsync SHALL be 0 exactly for col in [ACTIVE_COLS+H_FRONT_PORCH, ACTIVE_COLS+H_FRONT_PORCH+H_SYNC_WIDTH-1], else 1 (defaults: 656..751).
REQ-009 vsync SHALL be 0 exactly for row in [ACTIVE_ROWS+V_FRONT_PORCH, ACTIVE_ROWS+V_FRONT_PORCH+V_SYNC_WIDTH-1], for all columns of those rows, else 1 (defaults: 490..491).
REQ-010 framestart SHALL be 1 only in the cycle following an enabled edge that moves (col,row) to (0,0), including the first edge after reset release.
REQ-011 Comparisons SHALL be unsigned at 10 bits; parameters SHALL satisfy ACTIVE+FRONT_PORCH+SYNC_WIDTH <= TOTAL <= 1024 per axis; violation SHALL be flagged at elaboration (simulation $error).

Reset
REQ-012 While reset_n=0 at a clock edge: col=TOTAL_COLS-1, row=TOTAL_ROWS-1, hsync=1, vsync=1, active=0, framestart=0.
REQ-013 The first edge with reset_n=1 and enable=1 SHALL produce col=0, row=0, active=1, framestart=1.
REQ-014 Reset asserted mid-frame SHALL override enable and restore REQ-012 values on that edge; no partial line or frame SHALL continue afterwards.

Structure
REQ-015 Default 640x480@60 timing constants (totals, actives, porches, sync widths) SHALL live in the shared vga_timing package/include, also used by the pattern and sync-to-count blocks.
REQ-016 One sub-module, vga_axis_timing, SHALL implement a single axis (counter, wrap, sync window, active window) and be instantiated twice, horizontal and vertical, the vertical instance advanced by the horizontal wrap.

Verification
REQ-017 Reset held 5 cycles, released with enable=1 -> cycle 1: col=0,row=0,active=1,framestart=1; col=639 active=1; col=640 active=0.
REQ-018 Run one line -> hsync=0 for exactly 96 consecutive cycles, first at col=656, last at col=751; line period 800 cycles.
REQ-019 Run full frame -> vsync=0 for exactly 1600 cycles (rows 490..491), framestart period 420000 cycles, row wraps 524->0 with col 799->0.
REQ-020 enable toggled 0 for 7 cycles at col=655 -> outputs frozen, hsync stays 1, resumes col=656 with hsync=0; framestart never asserted during hold.
REQ-021 reset_n pulsed low at col=700,row=491 -> next cycle col=799,row=524,hsync=1,vsync=1,active=0; next enabled edge gives framestart=1.
REQ-022 Non-default params (TOTAL 10x6, ACTIVE 4x3, porches 1, syncs 2) -> hsync low at cols 5..6, vsync low at rows 4..5, frame period 60 cycles.
